// File: rtl/if_id_lmsm_seq.sv
// IF/ID pipeline register with an LM/SM micro-sequencer.
// Ordinary instructions pass through with one cycle of latency. An LM/SM
// carrying N list bits in IR[7:0] is replayed as N beats. Each beat clears
// the lowest remaining list bit, so decode always picks the next register
// by lowest-set-bit priority. Fetch is held while more than one beat remains.
//
// Handshake: fetch presents in_valid/in_IR/in_PC. The word is consumed at a
// rising edge only when fetch_hold is low at that edge. While fetch_hold is
// high, fetch must keep PC and its instruction unchanged. The register
// ignores in_* whenever a sequence is pending or stall is high.
//
// The sequencer state is implicit in the held instruction:
// SEQ == pending (a valid LM/SM with two or more list bits left), PASS otherwise.
module if_id_lmsm_seq #(
  parameter logic [15:0] NOP_IR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_IR,
  input  logic [15:0] in_PC,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] IR,
  output logic [15:0] fromPipe1PC,
  output logic        valid,
  output logic [2:0]  lmsm_index,
  output logic        lmsm_last,
  output logic        fetch_hold
);

  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [2:0]  idx_q, idx_d;

  logic [7:0]  list;
  logic [3:0]  list_cnt;
  logic        is_lmsm;
  logic        pending;
  logic        in_is_lmsm;

  // State register: asynchronous reset drops any sequence in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= NOP_IR;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // Decode the held instruction: list popcount and the implicit SEQ state.
  always_comb begin
    list     = ir_q[7:0];
    list_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      list_cnt = list_cnt + {3'b000, list[i]};
    end
    is_lmsm    = valid_q && (ir_q[15:13] == 3'b011);
    pending    = is_lmsm && (list_cnt >= 4'd2);
    in_is_lmsm = (in_IR[15:13] == 3'b011);
  end

  // Next-state logic. Priority: flush, stall, sequencing, then fetch load.
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (flush) begin
      ir_d    = NOP_IR;
      valid_d = 1'b0;
      idx_d   = 3'd0;
    end else if (!stall) begin
      if (pending) begin
        // Clear the lowest set list bit. Bit 8 and the opcode stay untouched.
        ir_d[7:0] = list & (list - 8'd1);
        idx_d     = idx_q + 3'd1;
      end else if (in_valid) begin
        pc_d  = in_PC;
        idx_d = 3'd0;
        if (in_is_lmsm && (in_IR[7:0] == 8'h00)) begin
          // An empty register list does no work. Record its PC behind a bubble.
          ir_d    = NOP_IR;
          valid_d = 1'b0;
        end else begin
          ir_d    = in_IR;
          valid_d = 1'b1;
        end
      end else begin
        ir_d    = NOP_IR;
        valid_d = 1'b0;
        idx_d   = 3'd0;
      end
    end
  end

  // Outputs: registered fields plus combinational beat/hold status.
  always_comb begin
    IR          = ir_q;
    fromPipe1PC = pc_q;
    valid       = valid_q;
    lmsm_index  = idx_q;
    lmsm_last   = is_lmsm && (list_cnt == 4'd1);
    fetch_hold  = stall || (pending && !flush);
  end

endmodule

// File: doc/if_id_lmsm_seq.md
# if_id_lmsm_seq

Fetch-to-decode pipeline register with an LM/SM micro-sequencer. It sits directly upstream of the decode stage and drives that stage's `IR` and `fromPipe1PC` inputs. Ordinary instructions pass through with one cycle of latency. An LM or SM whose register list has N set bits in `IR[7:0]` is expanded into N consecutive beats, each with the lowest remaining list bit cleared. Decode therefore always resolves the next register via its lowest-set-bit priority. Fetch is held while beats remain.

## Interface
Parameters:
- `NOP_IR`, default 16'hF000: bubble instruction. Opcode 1111 hits the decode default case, so nothing is written.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a valid instruction this cycle
- `in_IR`  in  16  fetched instruction
- `in_PC`  in  16  PC of the fetched instruction
- `stall`  in  1  downstream hazard; hold all state
- `flush`  in  1  branch/jump redirect; squash held contents
- `IR`  out  16  registered instruction to decode
- `fromPipe1PC`  out  16  registered PC to decode
- `valid`  out  1  `IR` is a real instruction, not a bubble
- `lmsm_index`  out  3  beat number within the current LM/SM (0 = first beat); used for address RA+index
- `lmsm_last`  out  1  current beat is the final beat of an LM/SM
- `fetch_hold`  out  1  fetch must not advance PC or present a new instruction

## Operation
- Reset (asynchronous, `reset_n`=0) sets: `IR`=NOP_IR, `fromPipe1PC`=0, `valid`=0, `lmsm_index`=0. Combinational outputs then read `lmsm_last`=0 and `fetch_hold`=`stall`.
- Definitions:
  - `is_lmsm` = (`IR[15:13]`==3'b011) and `valid`.
  - `L` = `IR[7:0]`.
  - `pending` = `is_lmsm` and popcount(L) ≥ 2.
- `lmsm_last` = `is_lmsm` and popcount(L) == 1. This is combinational.
- `fetch_hold` = `stall` or (`pending` and not `flush`). This is combinational.
- The edge update follows this priority order:
  1. `flush`=1: load the bubble (`IR`=NOP_IR, `valid`=0, `lmsm_index`=0). `fromPipe1PC` holds. Any sequence is abandoned.
  2. `stall`=1: all registers hold.
  3. `pending`=1: `IR[7:0]` becomes L with its lowest set bit cleared. `IR[15:8]`, including list bit 8, is unchanged. `fromPipe1PC` holds. `lmsm_index` increments by 1. `in_*` is ignored.
  4. Otherwise, if `in_valid`=1:
     - Load `in_IR`/`in_PC`, set `valid`=1, `lmsm_index`=0.
     - Exception: if `in_IR` is LM/SM with `in_IR[7:0]`==0, load the bubble instead (`valid`=0) and record `in_PC` into `fromPipe1PC`.
  5. Otherwise (`in_valid`=0): load the bubble; `fromPipe1PC` holds.
- Sequencer states are implicit:
  - PASS: not `pending`.
  - SEQ: `pending`.
  - PASS→SEQ when an LM/SM with popcount ≥ 2 is loaded.
  - SEQ→PASS when the beat with popcount 1 is reached, or on `flush`.
- `lmsm_index` ranges 0–7 and never wraps within a legal sequence (at most 8 beats). Bit 8 of the list is never sequenced or cleared.
- Non-LM/SM instructions never assert `pending`, even if their bits [7:0] are nonzero.

## Timing
- Pass-through latency is 1 cycle: `in_IR` sampled at edge k appears on `IR` after edge k.
- An LM/SM with N≥1 list bits occupies N consecutive non-stalled cycles. `fetch_hold` is high during the first N−1 of them. The instruction following it is accepted at the edge that ends the `lmsm_last` beat.
- Stall during SEQ freezes the beat: `IR` and `lmsm_index` are unchanged, and `fetch_hold` stays 1.
- `flush` and `stall` together: flush wins and the bubble is loaded.
- `flush` during SEQ: the bubble appears after the edge, and `fetch_hold` drops in the same cycle `flush` is high.
- Reset asserted mid-sequence: outputs go to reset values immediately, without waiting for a clock. The sequence is lost.

## Test plan
- Reset then ADD pass-through: hold `reset_n`=0, then release; present `in_IR`=16'h0298, `in_PC`=16'h0010, `in_valid`=1 → after one edge `IR`=16'h0298, `fromPipe1PC`=16'h0010, `valid`=1, `fetch_hold`=0.
- LM expansion: `in_IR`=16'h6025 (list 0x25) → IR sequence 16'h6025, 16'h6024, 16'h6020 with `lmsm_index` 0,1,2; `fetch_hold`=1,1,0; `lmsm_last`=0,0,1; the next fetched instruction appears on the 4th cycle.
- Stall mid-SM: `in_IR`=16'h7083, assert `stall` for 2 cycles on beat 1 → `IR`=16'h7082 and `lmsm_index`=1 held for 3 cycles, then 16'h7080 with index 2.
- Flush mid-sequence: LM 16'h60FF, assert `flush` on beat 2 → next `IR`=16'hF000, `valid`=0, `lmsm_index`=0, `fetch_hold`=0 during the flush cycle.
- Empty-list LM and bit 8: `in_IR`=16'h6000 → bubble, `valid`=0, `fromPipe1PC`=`in_PC`. `in_IR`=16'h6101 → single beat, `lmsm_last`=1, bit 8 retained.
- Async reset mid-SEQ: drop `reset_n` between clock edges during LM 16'h600F → `IR`=16'hF000, `valid`=0, `lmsm_index`=0 before the next edge.
